// File: rtl/lw_sha_fifo_interface_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lw_sha_fifo_interface_ctrl
// Desc   : Bus register file, word packer and data FIFO in front of a SHA core.
// Rev    : 1.0 - initial release
// ============================================================================
module lw_sha_fifo_interface_ctrl #(
  parameter int          BUS_W      = 32,
  parameter int          WORD_W     = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ID_VAL     = 32'h0
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                wr_i,
  input  logic [11:0]         waddr_i,
  input  logic [BUS_W-1:0]    wdata_i,
  output logic                wr_ack_o,
  input  logic                rd_i,
  input  logic [11:0]         raddr_i,
  output logic [BUS_W-1:0]    rdata_o,
  output logic                read_valid_o,
  output logic                slv_error_o,
  input  logic [8*WORD_W-1:0] hash_i,
  input  logic                done_i,
  input  logic                core_ready_i,
  output logic [WORD_W-1:0]   data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o,
  output logic                start_o,
  output logic                abort_o,
  output logic [3:0]          opcode_o,
  output logic                core_reset_o,
  output logic                irq_o
);
  localparam int          c_P      = WORD_W / BUS_W;
  localparam int          c_AW     = $clog2(FIFO_DEPTH);
  localparam int          c_CW     = c_AW + 1;
  localparam int          c_HW     = 8 * WORD_W;
  localparam int          c_SLICES = c_HW / BUS_W;
  localparam int          c_BSH    = $clog2(BUS_W / 8);
  localparam logic [11:0] c_A_ID   = 12'h000;
  localparam logic [11:0] c_A_CFG  = 12'h010;
  localparam logic [11:0] c_A_CTL  = 12'h020;
  localparam logic [11:0] c_A_STS  = 12'h030;
  localparam logic [11:0] c_A_IE   = 12'h040;
  localparam logic [11:0] c_A_LVL  = 12'h050;
  localparam logic [11:0] c_A_DIN  = 12'h140;
  localparam logic [11:0] c_A_DINL = 12'h148;

  logic [3:0]        r_opcode;
  logic [6:0]        r_ie;
  logic              r_ovf, r_derr, r_avl;
  logic              r_wr_ack, r_rvalid, r_slv_err, r_start, r_abort, r_core_rst_n, r_irq;
  logic [BUS_W-1:0]  r_rdata;
  logic [c_AW-1:0]   r_wptr, r_rptr;
  logic [c_CW-1:0]   r_count;
  logic [WORD_W:0]   r_mem [FIFO_DEPTH];

  logic              w_cfg_wr, w_ctl_wr, w_sts_wr, w_ie_wr, w_din_wr, w_din_last;
  logic              w_srst, w_init, w_abort, w_flush;
  logic              w_full, w_empty, w_pop, w_completes, w_push_req, w_push_ok, w_push_rej;
  logic [WORD_W-1:0] w_push_data;
  logic [6:0]        w_sts;
  logic [31:0]       w_reg32, w_hidx;
  logic [BUS_W-1:0]  w_rd_val;
  logic              w_rd_err, w_hash_hit;
  logic [c_HW-1:0]   w_hash_sh;

  assign w_cfg_wr   = wr_i && (waddr_i == c_A_CFG);
  assign w_ctl_wr   = wr_i && (waddr_i == c_A_CTL);
  assign w_sts_wr   = wr_i && (waddr_i == c_A_STS);
  assign w_ie_wr    = wr_i && (waddr_i == c_A_IE);
  assign w_din_last = (waddr_i == c_A_DINL);
  assign w_din_wr   = wr_i && ((waddr_i == c_A_DIN) || w_din_last);
  assign w_srst     = w_cfg_wr && wdata_i[31];
  // Abort dominates init when both bits are written together.
  assign w_abort    = w_ctl_wr && wdata_i[2];
  assign w_init     = w_ctl_wr && wdata_i[0] && !wdata_i[2];
  assign w_flush    = w_ctl_wr && (wdata_i[0] || wdata_i[2]);

  assign w_full     = (r_count == c_CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && ready_i;
  assign w_push_req = w_din_wr && w_completes;
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_push_rej = w_push_req && !w_push_ok;
  assign w_sts      = {r_ovf, w_empty, !core_ready_i, r_derr, 1'b0, !w_full, r_avl};

  generate
    if (c_P == 2) begin : g_pack2
      logic             r_pk_full;
      logic [BUS_W-1:0] r_pk_upper;
      // A rejected completing write leaves the held upper half in place.
      always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
          r_pk_full  <= 1'b0;
          r_pk_upper <= '0;
        end else if (w_srst || w_flush) begin
          r_pk_full  <= 1'b0;
          r_pk_upper <= '0;
        end else if (w_din_wr && !r_pk_full) begin
          r_pk_full  <= 1'b1;
          r_pk_upper <= wdata_i;
        end else if (w_push_ok) begin
          r_pk_full  <= 1'b0;
        end
      end
      assign w_completes = r_pk_full;
      assign w_push_data = {r_pk_upper, wdata_i};
    end else begin : g_pack1
      assign w_completes = 1'b1;
      assign w_push_data = wdata_i;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr] <= {w_din_last, w_push_data};
  end

  // Hash slices are read big-endian: offset 0 is the top BUS_W bits of word 7.
  assign w_hidx     = 32'(raddr_i[5:c_BSH]);
  assign w_hash_hit = (raddr_i[11:6] == 6'h04) && (raddr_i[c_BSH-1:0] == '0) &&
                      (w_hidx < c_SLICES);
  assign w_hash_sh  = hash_i << (w_hidx * BUS_W);

  always_comb begin
    w_reg32  = '0;
    w_rd_err = 1'b0;
    case (raddr_i)
      c_A_ID:  w_reg32 = ID_VAL;
      c_A_CFG: w_reg32 = {28'd0, r_opcode};
      c_A_CTL: w_reg32 = '0;
      c_A_STS: w_reg32 = {25'd0, w_sts};
      c_A_IE:  w_reg32 = {25'd0, r_ie};
      c_A_LVL: w_reg32 = 32'(r_count);
      default: w_rd_err = 1'b1;
    endcase
    w_rd_val        = '0;
    w_rd_val[31:0]  = w_reg32;
    if (w_hash_hit) begin
      w_rd_val = w_hash_sh[c_HW-1 -: BUS_W];
      w_rd_err = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_opcode <= '0; r_ie <= 7'h02; r_ovf <= 1'b0; r_derr <= 1'b0; r_avl <= 1'b0;
      r_wr_ack <= 1'b0; r_rvalid <= 1'b0; r_slv_err <= 1'b0; r_start <= 1'b0;
      r_abort <= 1'b0; r_core_rst_n <= 1'b1; r_irq <= 1'b0; r_rdata <= '0;
      r_wptr <= '0; r_rptr <= '0; r_count <= '0;
    end else if (w_srst) begin
      r_opcode <= '0; r_ie <= 7'h02; r_ovf <= 1'b0; r_derr <= 1'b0; r_avl <= 1'b0;
      r_wr_ack <= 1'b1; r_rvalid <= 1'b0; r_slv_err <= 1'b0; r_start <= 1'b0;
      r_abort <= 1'b0; r_core_rst_n <= 1'b0; r_irq <= 1'b0; r_rdata <= '0;
      r_wptr <= '0; r_rptr <= '0; r_count <= '0;
    end else begin
      r_wr_ack     <= wr_i;
      r_core_rst_n <= 1'b1;
      r_rvalid     <= rd_i;
      if (rd_i) r_rdata <= w_rd_val;
      r_slv_err    <= (rd_i && w_rd_err) || w_push_rej;
      r_start      <= w_init;
      r_abort      <= w_abort;
      if (w_cfg_wr) r_opcode <= wdata_i[3:0];
      if (w_ie_wr)  r_ie     <= wdata_i[6:0];
      r_ovf  <= w_push_rej || (r_ovf  && !(w_sts_wr && wdata_i[6]));
      r_derr <= w_push_rej || (r_derr && !(w_sts_wr && wdata_i[3]));
      r_avl  <= done_i || (r_avl && !(w_sts_wr && wdata_i[0]) && !w_init);
      r_irq  <= |(w_sts & r_ie);
      if (w_flush) begin
        r_wptr <= '0; r_rptr <= '0; r_count <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + 1'b1;
        if (w_pop)     r_rptr <= r_rptr + 1'b1;
        if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  assign wr_ack_o     = r_wr_ack;
  assign rdata_o      = r_rdata;
  assign read_valid_o = r_rvalid;
  assign slv_error_o  = r_slv_err;
  assign valid_o      = !w_empty;
  assign data_o       = w_empty ? '0 : r_mem[r_rptr][WORD_W-1:0];
  assign last_o       = !w_empty && r_mem[r_rptr][WORD_W];
  assign start_o      = r_start;
  assign abort_o      = r_abort;
  assign opcode_o     = r_opcode;
  assign core_reset_o = r_core_rst_n;
  assign irq_o        = r_irq;
endmodule
`default_nettype wire

// File: doc/lw_sha_fifo_interface_ctrl.md
LW_SHA_FIFO_INTERFACE_CTRL -- requirements
Module: lw_sha_fifo_interface_ctrl

Interface
REQ-001 SHALL have parameter BUS_W, default 32, bus data width (32 or 64).
REQ-002 SHALL have parameter WORD_W, default 64, core word width (32 or 64, WORD_W >= BUS_W).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, data FIFO entries (power of 2, 2..16).
REQ-004 SHALL have parameter ID_VAL, default 32'h0, ID register value.
REQ-005 SHALL have ports, as name / direction / width / meaning:
- clk_i  in  1  single clock.
- resetn_i  in  1  asynchronous active-low reset.
- wr_i  in  1  bus write strobe.
- waddr_i  in  12  write address.
- wdata_i  in  BUS_W  write data.
- wr_ack_o  out  1  write acknowledge.
- rd_i  in  1  read strobe.
- raddr_i  in  12  read address.
- rdata_o  out  BUS_W  read data.
- read_valid_o  out  1  read data valid.
- slv_error_o  out  1  bus error pulse.
- hash_i  in  8*WORD_W  core digest; word 7 is most significant.
- done_i  in  1  core done pulse.
- core_ready_i  in  1  core idle.
- data_o  out  WORD_W  FIFO head word.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  core accepts word.
- last_o  out  1  head word carries last tag.
- start_o  out  1  init pulse.
- abort_o  out  1  abort pulse.
- opcode_o  out  4  CFG[3:0].
- core_reset_o  out  1  active-low core soft reset.
- irq_o  out  1  registered interrupt.

Function
REQ-006 Map SHALL be: ID 0x000 RO; CFG 0x010 ([31] srst, [3:0] opcode); CTL 0x020 ([2] abort, [1] reserved, [0] init); STS 0x030; IE 0x040 ([6:0]); LVL 0x050 RO (FIFO count); HASH 0x100-0x13F RO; DIN 0x140 WO; DIN_LAST 0x148 WO.
REQ-007 STS SHALL be: [6] ovf W1C, [5] empty live, [4] busy = !core_ready_i live, [3] derr W1C, [1] rdyd = !full live, [0] avl W1C; all other bits read 0.
REQ-008 wr_ack_o SHALL pulse 1 cycle, the cycle after every wr_i, for any address.
REQ-009 read_valid_o SHALL pulse 1 cycle after rd_i; rdata_o SHALL be registered and hold until the next read.
REQ-010 An unmapped read or a read of a WO address SHALL return 0 with read_valid_o set and pulse slv_error_o.
REQ-011 HASH reads SHALL be big-endian: offset 0 returns hash_i[8*WORD_W-1 -: BUS_W], each following BUS_W/8-byte offset returns the next lower slice.
REQ-012 Packer: with P = WORD_W/BUS_W = 2, the first DIN/DIN_LAST write SHALL fill the upper half and the second write SHALL fill the lower half and push; with P = 1, each write SHALL push.
REQ-013 The last tag SHALL be taken from the address of the write that completes the word.
REQ-014 A push SHALL be accepted when !full or when a pop occurs in the same cycle.
REQ-015 A rejected push SHALL leave the FIFO and packer unchanged, set derr and ovf, and pulse slv_error_o.
REQ-016 A pop SHALL occur when valid_o && ready_i; data_o and last_o SHALL show the head entry; a simultaneous push and pop SHALL leave the count unchanged.
REQ-017 Pointers SHALL wrap modulo FIFO_DEPTH; LVL SHALL read 0..FIFO_DEPTH.
REQ-018 A CTL write with bit0=1 SHALL produce a 1-cycle start_o on the next cycle, clear avl, and flush the FIFO and packer; bit0 SHALL self-clear.
REQ-019 A CTL write with bit2=1 SHALL produce a 1-cycle abort_o on the next cycle and flush the FIFO and packer; when bit0 and bit2 are set together, abort SHALL win and no start_o SHALL be issued.
REQ-020 done_i SHALL set avl; when done_i and an avl W1C occur in the same cycle, the set SHALL win.
REQ-021 irq_o SHALL be registered as the OR of STS[6:0] & IE[6:0], one cycle after the source changes.
REQ-022 A CFG write with bit31=1 SHALL, on the next cycle, restore all registers, the FIFO and the packer to reset values and drive core_reset_o low for exactly 1 cycle; srst SHALL read as 0.

Reset
REQ-023 On resetn_i low, all outputs SHALL be 0 except core_reset_o=1; CFG=0, CTL=0, IE=0x02, W1C bits=0, FIFO empty, packer empty, rdata_o=0.
REQ-024 Reset SHALL take effect asynchronously mid-operation; the first write after reset release SHALL be treated as a first half.

Verification
REQ-025 BUS_W=32, WORD_W=64: write DIN 0x11111111 then DIN_LAST 0x22222222 -> LVL=1, data_o=0x1111111122222222, valid_o=1, last_o=1.
REQ-026 FIFO_DEPTH=4 with ready_i=0: 5 complete words -> 5th rejected, STS reads 0x48 (derr, ovf, rdyd=0), slv_error_o pulses, LVL=4; write STS 0x48 -> STS reads 0x00.
REQ-027 FIFO full with ready_i=1 and a push in the same cycle -> push accepted, LVL remains 4, no derr.
REQ-028 IE=0x01, done_i pulse -> avl=1 and irq_o high 1 cycle later; write CTL=0x1 -> start_o pulses, avl=0, irq_o low.
REQ-029 hash_i = {w7..w0} with BUS_W=32 -> read 0x100 returns w7[63:32], read 0x13C returns w0[31:0]; read 0x200 returns 0 and pulses slv_error_o.
REQ-030 One half-word written, then CFG=0x80000000 -> core_reset_o low for 1 cycle, packer cleared, next DIN write fills the upper half.
